// File: rtl/sqrt_sequencer.sv
// Control sequencer for the bus-based odd-subtraction square-root datapath.
// It steps the {A,B,C,D} state code read by the controller decoder, counts
// completed loop iterations and flags a runaway loop. All outputs come from
// registers or from a decode of the registered state.
module sqrt_sequencer #(
  parameter int ITER_W   = 8,
  parameter int MAX_ITER = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              ge_flag,
  output logic [3:0]        state_code,
  output logic              busy,
  output logic              done,
  output logic [ITER_W-1:0] iter_cnt,
  output logic              err
);

  typedef enum logic [3:0] {
    IDLE     = 4'h0,
    LOAD_N   = 4'h1,
    INIT_ODD = 4'h2,
    INIT_Q   = 4'h3,
    SUB      = 4'h4,
    CHECK    = 4'h5,
    COMMIT   = 4'h6,
    INC_ODD  = 4'h7,
    INC_Q    = 4'h8,
    DONE     = 4'h9
  } state_t;

  localparam logic [ITER_W:0] MAX_V = (ITER_W+1)'(MAX_ITER);

  // The register holds raw bits so that every one of the 16 codes is
  // representable and the illegal-code recovery path is real logic.
  logic [3:0]      state_q;
  state_t          state_d;
  logic [ITER_W:0] cnt_inc;
  logic            last_iter;

  assign cnt_inc   = {1'b0, iter_cnt} + (ITER_W+1)'(1);
  assign last_iter = (cnt_inc == MAX_V);

  // Next-state decode; abort outranks every transition outside IDLE.
  always_comb begin
    state_d = IDLE;
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:     state_d = start ? LOAD_N : IDLE;
        LOAD_N:   state_d = INIT_ODD;
        INIT_ODD: state_d = INIT_Q;
        INIT_Q:   state_d = SUB;
        SUB:      state_d = CHECK;
        CHECK:    state_d = ge_flag ? COMMIT : DONE;
        COMMIT:   state_d = INC_ODD;
        INC_ODD:  state_d = INC_Q;
        INC_Q:    state_d = last_iter ? DONE : SUB;
        DONE:     state_d = IDLE;
        default:  state_d = IDLE;
      endcase
    end
  end

  // State register with asynchronous return to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= 4'h0;
    end else begin
      state_q <= state_d;
    end
  end

  // Iteration counter and sticky runaway flag; both freeze on abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iter_cnt <= '0;
      err      <= 1'b0;
    end else if (!abort) begin
      if (state_q == LOAD_N) begin
        iter_cnt <= '0;
        err      <= 1'b0;
      end else if (state_q == INC_Q) begin
        iter_cnt <= cnt_inc[ITER_W-1:0];
        if (last_iter) begin
          err <= 1'b1;
        end
      end
    end
  end

  assign state_code = state_q;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);

endmodule

// File: tb/tb_sqrt_sequencer.sv
// Randomised bench for sqrt_sequencer. Expected traces are built from the
// algorithm itself (Q = isqrt(N) bounded by MAX_ITER) and compared every cycle.
module tb_sqrt_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_a, start_b, abort, ge_flag;
  logic [3:0] sc0, sc1;
  logic       bz0, bz1, dn0, dn1, er0, er1;
  logic [7:0] ic0, ic1;

  always #5 clk = ~clk;

  sqrt_sequencer #(.ITER_W(8), .MAX_ITER(255)) dut (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort), .ge_flag(ge_flag),
    .state_code(sc0), .busy(bz0), .done(dn0), .iter_cnt(ic0), .err(er0));

  sqrt_sequencer #(.ITER_W(8), .MAX_ITER(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort), .ge_flag(ge_flag),
    .state_code(sc1), .busy(bz1), .done(dn1), .iter_cnt(ic1), .err(er1));

  int n_chk = 0;
  int n_pass = 0;

  bit sel;
  bit chk_en;
  int exp_sc, exp_cnt, exp_err;
  bit exp_cnt_vld;
  int mcnt[2];
  int merr[2];
  int tq_code[$];
  int tq_cnt[$];
  int tq_err[$];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // Per-cycle comparison of the selected DUT against the expected trace.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("state", sel ? int'(sc1) : int'(sc0), exp_sc);
      chk("busy",  sel ? int'(bz1) : int'(bz0), (exp_sc != 0) ? 1 : 0);
      chk("done",  sel ? int'(dn1) : int'(dn0), (exp_sc == 9) ? 1 : 0);
      if (exp_cnt_vld) chk("iter_cnt", sel ? int'(ic1) : int'(ic0), exp_cnt);
      chk("err",   sel ? int'(er1) : int'(er0), exp_err);
    end
  end

  // Expected (state, count, err) after each edge following the start edge.
  task automatic build(input int n, input int mx, input int oc, input int oe);
    int q;
    bit e;
    tq_code.delete(); tq_cnt.delete(); tq_err.delete();
    q = 0;
    while (q < mx && (q + 1) * (q + 1) <= n) q++;
    e = (q == mx);
    tq_code.push_back(1); tq_cnt.push_back(oc); tq_err.push_back(oe);
    tq_code.push_back(2); tq_cnt.push_back(0);  tq_err.push_back(0);
    tq_code.push_back(3); tq_cnt.push_back(0);  tq_err.push_back(0);
    for (int i = 0; i < q; i++) begin
      for (int c = 4; c <= 8; c++) begin
        tq_code.push_back(c); tq_cnt.push_back(i); tq_err.push_back(0);
      end
    end
    if (!e) begin
      tq_code.push_back(4); tq_cnt.push_back(q); tq_err.push_back(0);
      tq_code.push_back(5); tq_cnt.push_back(q); tq_err.push_back(0);
      tq_code.push_back(9); tq_cnt.push_back(q); tq_err.push_back(0);
    end else begin
      tq_code.push_back(9); tq_cnt.push_back(q); tq_err.push_back(1);
    end
    tq_code.push_back(0); tq_cnt.push_back(q); tq_err.push_back(int'(e));
  endtask

  task automatic set_start(input bit s, input logic v);
    if (s) start_b = v;
    else start_a = v;
  endtask

  // Called during an IDLE cycle (#1 after an edge); returns in an IDLE cycle.
  task automatic run(input int n, input int abort_k, input bit s, input int mx);
    int len, code;
    build(n, mx, mcnt[s], merr[s]);
    len = tq_code.size();
    sel = s; exp_sc = 0; exp_cnt = mcnt[s]; exp_err = merr[s]; exp_cnt_vld = 1;
    set_start(s, 1'b1); abort = 1'b0; ge_flag = 1'($urandom);
    for (int k = 1; k <= len; k++) begin
      @(posedge clk); #1;
      code = tq_code[k-1];
      exp_sc = code; exp_cnt = tq_cnt[k-1]; exp_err = tq_err[k-1];
      exp_cnt_vld = (code != 1);
      if (k == abort_k && code != 0) begin
        set_start(s, 1'($urandom)); abort = 1'b1; ge_flag = 1'($urandom);
        @(posedge clk); #1;
        abort = 1'b0; set_start(s, 1'b0);
        if (code != 1) begin
          mcnt[s] = tq_cnt[k-1]; merr[s] = tq_err[k-1];
        end
        exp_sc = 0; exp_cnt = mcnt[s]; exp_err = merr[s]; exp_cnt_vld = 1;
        return;
      end
      set_start(s, (code != 0) ? 1'($urandom) : 1'b0);
      ge_flag = (code == 5) ? ((exp_cnt + 1) * (exp_cnt + 1) <= n) : 1'($urandom);
    end
    mcnt[s] = tq_cnt[len-1]; merr[s] = tq_err[len-1];
  endtask

  task automatic idle(input int cyc);
    for (int i = 0; i < cyc; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start_a = 1'b1; start_b = 1'b1; abort = 1'b0; ge_flag = 1'b0;
    chk_en = 0; sel = 0;
    mcnt[0] = 0; mcnt[1] = 0; merr[0] = 0; merr[1] = 0;
    exp_sc = 0; exp_cnt = 0; exp_err = 0; exp_cnt_vld = 1;

    // Reset held with start asserted.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", int'(sc0), 0);
    chk("rst_busy", int'(bz0), 0);
    chk("rst_done", int'(dn0), 0);
    chk("rst_iter", int'(ic0), 0);
    chk("rst_err", int'(er0), 0);
    chk("rst_state3", int'(sc1), 0);
    @(negedge clk);
    rst_n = 1'b1; start_a = 1'b0; start_b = 1'b0;
    @(posedge clk); #1;
    chk_en = 1;

    // Hand-computed pins on the trace model.
    build(0, 255, 0, 0);
    chk("model_n0_len", tq_code.size(), 7);
    chk("model_n0_done_edge6", tq_code[5], 9);
    build(16, 255, 0, 0);
    chk("model_n16_done_edge26", tq_code[25], 9);
    chk("model_n16_q", tq_cnt[25], 4);
    build(100, 3, 0, 0);
    chk("model_run_inc_q", tq_code[tq_code.size()-3], 8);
    chk("model_run_err", tq_err[tq_code.size()-2], 1);
    chk("model_run_cnt", tq_cnt[tq_code.size()-2], 3);

    // Directed runs.
    run(0, -1, 0, 255);
    chk("n0_iter", int'(ic0), 0);
    run(16, -1, 0, 255);
    chk("n16_iter", int'(ic0), 4);
    chk("n16_err", int'(er0), 0);
    run(16, 11, 0, 255);
    chk("abort_iter_held", int'(ic0), 1);
    idle(2);
    run(16, -1, 0, 255);
    run(100, -1, 1, 3);
    chk("runaway_iter", int'(ic1), 3);
    chk("runaway_err", int'(er1), 1);
    run(4, -1, 1, 3);
    chk("err_cleared", int'(er1), 0);
    chk("after_err_iter", int'(ic1), 2);

    // Randomised runs on both instances.
    for (int r = 0; r < 30; r++) begin
      bit s;
      int n, ak;
      s = ($urandom_range(0, 3) == 0);
      n = s ? int'($urandom_range(0, 20)) : int'($urandom_range(0, 300));
      ak = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 60)) : -1;
      run(n, ak, s, s ? 3 : 255);
      idle(int'($urandom_range(0, 2)));
    end

    // Illegal state code recovery.
    chk_en = 0; sel = 0;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_force_sub", int'(sc0), 4);
    force dut.state_q = 4'hC;
    #2;
    chk("forced_code", int'(sc0), 12);
    @(posedge clk); #1;
    release dut.state_q;
    @(posedge clk); #1;
    chk("illegal_to_idle", int'(sc0), 0);
    chk("illegal_iter", int'(ic0), 0);

    // Asynchronous reset in SUB.
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_reset_sub", int'(sc0), 4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_state", int'(sc0), 0);
    chk("async_rst_busy", int'(bz0), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_idle", int'(sc0), 0);
    mcnt[0] = 0; mcnt[1] = 0; merr[0] = 0; merr[1] = 0;
    exp_sc = 0; exp_cnt = 0; exp_err = 0; exp_cnt_vld = 1;
    chk_en = 1;
    run(9, -1, 0, 255);
    chk("restart_iter", int'(ic0), 3);
    chk_en = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
